// File: rtl/piso_serializer_pkg.sv
// Shared types for the serial framer: shifter state encoding and the start-bit level.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } ser_state_t;

  localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer: one-word holding buffer feeding a shifter that emits
// an optional start bit plus W data bits, one bit per clock, on registered outputs.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1,
  parameter int FRAMED    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         busy
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  ser_state_t    r_state;
  logic [W-1:0]  r_hold;
  logic          r_hold_full;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_dout_valid;

  logic          w_accept;
  logic          w_last;
  logic          w_reload;
  logic          w_bypass;
  logic [W-1:0]  w_next_word;

  function automatic logic first_bit(input logic [W-1:0] word);
    return (MSB_FIRST != 0) ? word[W-1] : word[0];
  endfunction

  function automatic logic [W-1:0] shift_once(input logic [W-1:0] word);
    return (MSB_FIRST != 0) ? {word[W-2:0], 1'b0} : {1'b0, word[W-1:1]};
  endfunction

  assign in_ready    = rst & ~r_hold_full;
  assign w_accept    = in_valid & in_ready;
  assign w_last      = (r_state == DATA) && (r_cnt == LAST_IDX);
  // A word accepted on the last-bit edge with an empty buffer goes straight to the shifter.
  assign w_bypass    = w_last & ~r_hold_full & w_accept;
  assign w_reload    = ((r_state == IDLE) && r_hold_full) || (w_last && (r_hold_full || w_accept));
  assign w_next_word = r_hold_full ? r_hold : in_data;

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign busy        = (r_state != IDLE) | r_hold_full;

  // Holding buffer and shifter FSM with registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_accept && !w_bypass) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end else begin
        r_hold_full <= r_hold_full;
      end

      if (w_reload) begin
        r_cnt        <= '0;
        r_dout_valid <= 1'b1;
        if (FRAMED != 0) begin
          r_state <= START;
          r_shift <= w_next_word;
          r_dout  <= START_BIT;
        end else begin
          r_state <= DATA;
          r_shift <= shift_once(w_next_word);
          r_dout  <= first_bit(w_next_word);
        end
      end else begin
        case (r_state)
          START: begin
            r_state      <= DATA;
            r_shift      <= shift_once(r_shift);
            r_dout       <= first_bit(r_shift);
            r_dout_valid <= 1'b1;
            r_cnt        <= '0;
          end
          DATA: begin
            if (w_last) begin
              r_state      <= IDLE;
              r_dout       <= 1'b0;
              r_dout_valid <= 1'b0;
            end else begin
              r_shift      <= shift_once(r_shift);
              r_dout       <= first_bit(r_shift);
              r_dout_valid <= 1'b1;
              r_cnt        <= r_cnt + CW'(1);
            end
          end
          IDLE: begin
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
          end
          default: begin
            r_state      <= IDLE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: default MSB-first framed instance plus an
// LSB-first unframed instance, with a 4-stage delay line standing in for shift_register.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic       dout_valid;
  logic       busy;

  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_dout;
  logic       l_dout_valid;
  logic       l_busy;

  logic [3:0] r_dly;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.W(8), .MSB_FIRST(1), .FRAMED(1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  piso_serializer #(.W(8), .MSB_FIRST(0), .FRAMED(0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .dout(l_dout), .dout_valid(l_dout_valid), .busy(l_busy)
  );

  // Downstream shift_register model, N=4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_dly <= 4'd0;
    else      r_dly <= {r_dly[2:0], dout};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_tests++;
    if ({dout, dout_valid, in_ready, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: got dout/valid/ready/busy=%b expected 0000", {dout, dout_valid, in_ready, busy});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midframe_active: got dout_valid=%b expected 1", dout_valid);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({dout, dout_valid, in_ready, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_midframe: got dout/valid/ready/busy=%b expected 0000", {dout, dout_valid, in_ready, busy});
    end
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midframe_release_ready: got %b expected 1", in_ready);
    end
    tick();
    n_tests++;
    if ({dout_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_frame_lost: got valid/busy=%b expected 00", {dout_valid, busy});
    end
  endtask

  task automatic test_single;
    logic [8:0] exp;
    exp = 9'b1_1010_0101;
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      tick();
      n_tests++;
      if (i <= 8) begin
        if ({dout, dout_valid} !== {exp[8-i], 1'b1}) begin
          n_fail++;
          $display("FAIL single_bit[%0d]: got dout/valid=%b%b expected %b1", i, dout, dout_valid, exp[8-i]);
        end
      end else begin
        if ({dout, dout_valid} !== 2'b00) begin
          n_fail++;
          $display("FAIL single_idle[%0d]: got dout/valid=%b%b expected 00", i, dout, dout_valid);
        end
      end
      if (i >= 4) begin
        n_tests++;
        if (r_dly[3] !== exp[8-(i-4)]) begin
          n_fail++;
          $display("FAIL single_delayed[%0d]: got %b expected %b", i - 4, r_dly[3], exp[8-(i-4)]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp;
    logic        exp_rdy;
    exp = {1'b1, 8'hFF, 1'b1, 8'h00};
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_after_accept: got %b expected 0", in_ready);
    end
    in_data = 8'h00;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      exp_rdy = !(k >= 1 && k <= 8);
      n_tests++;
      if ({dout, dout_valid, in_ready} !== {exp[17-k], 1'b1, exp_rdy}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got dout/valid/ready=%b%b%b expected %b1%b", k, dout, dout_valid, in_ready, exp[17-k], exp_rdy);
      end
    end
    tick();
    n_tests++;
    if ({dout_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end: got valid/busy=%b expected 00", {dout_valid, busy});
    end
  endtask

  task automatic test_lsb_unframed;
    l_in_valid = 1'b1; l_in_data = 8'h01;
    tick();
    l_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({l_dout, l_dout_valid} !== {(i == 0) ? 1'b1 : 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL lsb_bit[%0d]: got dout/valid=%b%b expected %b1", i, l_dout, l_dout_valid, (i == 0) ? 1'b1 : 1'b0);
      end
    end
    tick();
    n_tests++;
    if (l_dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_end: got valid=%b expected 0", l_dout_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [35:0] exp;
    exp = {1'b1, 8'h40, 1'b1, 8'h42, 1'b1, 8'h4B, 1'b1, 8'h54};
    in_valid = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      in_data = 8'h40 + 8'(c);
      if (c >= 21) in_valid = 1'b0;
      tick();
      if (c >= 1) begin
        n_tests++;
        if ({dout, dout_valid} !== {exp[35-(c-1)], 1'b1}) begin
          n_fail++;
          $display("FAIL bp_bit[%0d]: got dout/valid=%b%b expected %b1", c - 1, dout, dout_valid, exp[35-(c-1)]);
        end
      end
    end
    tick();
    n_tests++;
    if ({dout_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_end: got valid/busy=%b expected 00", {dout_valid, busy});
    end
  endtask

  task automatic test_same_edge;
    logic [7:0] w;
    w = 8'h3C;
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    in_valid = 1'b1; in_data = w;
    n_tests++;
    if ({dout, dout_valid, in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL same_edge_lastbit: got dout/valid/ready=%b%b%b expected 111", dout, dout_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if ({dout, dout_valid, in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL same_edge_start: got dout/valid/ready=%b%b%b expected 111", dout, dout_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({dout, dout_valid} !== {w[7-i], 1'b1}) begin
        n_fail++;
        $display("FAIL same_edge_bit[%0d]: got dout/valid=%b%b expected %b1", i, dout, dout_valid, w[7-i]);
      end
    end
    tick();
    n_tests++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_edge_end: got valid=%b expected 0", dout_valid);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    l_in_data  = 8'h00;
    l_in_valid = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_unframed();
    test_backpressure();
    test_same_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
